// File: rtl/wb_result_queue.sv
// Writeback result queue: buffers two execute lanes and drains one result per cycle into the
// register-file write port, with youngest-match bypass lookup over pending entries.
module wb_result_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REG_W = 5,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [REG_W-1:0] in0_rd,
    input  logic [XLEN-1:0]  in0_data,
    input  logic             in1_valid,
    input  logic [REG_W-1:0] in1_rd,
    input  logic [XLEN-1:0]  in1_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [REG_W-1:0] wr_addr,
    output logic [XLEN-1:0]  wr_data,
    input  logic [REG_W-1:0] byp_raddr1,
    input  logic [REG_W-1:0] byp_raddr2,
    output logic             byp_hit1,
    output logic [XLEN-1:0]  byp_data1,
    output logic             byp_hit2,
    output logic [XLEN-1:0]  byp_data2,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    logic [REG_W-1:0] mem_rd_q   [DEPTH];
    logic [REG_W-1:0] mem_rd_d   [DEPTH];
    logic [XLEN-1:0]  mem_data_q [DEPTH];
    logic [XLEN-1:0]  mem_data_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;

    logic          req0, req1;
    logic          enq0, enq1;
    logic          deq;
    logic [CW-1:0] enq_n;

    assign in_ready = (count_q <= CW'(DEPTH - 2));
    assign req0     = in0_valid && (in0_rd != '0);
    assign req1     = in1_valid && (in1_rd != '0);
    assign enq0     = req0 && in_ready;
    assign enq1     = req1 && in_ready;
    assign enq_n    = CW'(enq0) + CW'(enq1);
    assign deq      = (count_q != '0);

    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        if (enq0) begin
            mem_rd_d[tail_q]   = in0_rd;
            mem_data_d[tail_q] = in0_data;
        end
        // Lane 1 lands behind lane 0 when both enqueue, keeping program order.
        if (enq1) begin
            mem_rd_d[enq0 ? tail_q + PW'(1) : tail_q]   = in1_rd;
            mem_data_d[enq0 ? tail_q + PW'(1) : tail_q] = in1_data;
        end
        tail_d     = tail_q + enq_n[PW-1:0];
        head_d     = head_q + PW'(deq);
        count_d    = count_q + enq_n - CW'(deq);
        overflow_d = overflow_q | ((req0 || req1) && !in_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        wr_en   = deq;
        wr_addr = deq ? mem_rd_q[head_q] : '0;
        wr_data = deq ? mem_data_q[head_q] : '0;
    end

    // Walk oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q) begin
                if (byp_raddr1 != '0 && mem_rd_q[head_q + PW'(k)] == byp_raddr1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = mem_data_q[head_q + PW'(k)];
                end
                if (byp_raddr2 != '0 && mem_rd_q[head_q + PW'(k)] == byp_raddr2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = mem_data_q[head_q + PW'(k)];
                end
            end
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_wb_result_queue.sv
// Directed bench for wb_result_queue (DEPTH=4) with hand-computed expectations.
module tb_wb_result_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in0_valid, in1_valid;
    logic [4:0]  in0_rd, in1_rd;
    logic [31:0] in0_data, in1_data;
    logic        in_ready, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  byp_raddr1, byp_raddr2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
    logic [2:0]  count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    wb_result_queue #(.DEPTH(4), .XLEN(32), .REG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0_valid  (in0_valid),
        .in0_rd     (in0_rd),
        .in0_data   (in0_data),
        .in1_valid  (in1_valid),
        .in1_rd     (in1_rd),
        .in1_data   (in1_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .byp_raddr1 (byp_raddr1),
        .byp_raddr2 (byp_raddr2),
        .byp_hit1   (byp_hit1),
        .byp_data1  (byp_data1),
        .byp_hit2   (byp_hit2),
        .byp_data2  (byp_data2),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lane0(input logic v, input logic [4:0] rd, input logic [31:0] d);
        in0_valid = v;
        in0_rd    = rd;
        in0_data  = d;
    endtask

    task automatic lane1(input logic v, input logic [4:0] rd, input logic [31:0] d);
        in1_valid = v;
        in1_rd    = rd;
        in1_data  = d;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] a,
                          input logic [31:0] d, input logic [2:0] c);
        chk({tag, ".wr_en"}, 64'(wr_en), 64'(en));
        chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(a));
        chk({tag, ".wr_data"}, 64'(wr_data), 64'(d));
        chk({tag, ".count"}, 64'(count), 64'(c));
    endtask

    initial begin
        rst_n = 1'b0;
        lane0(1'b0, 5'd0, 32'h0);
        lane1(1'b0, 5'd0, 32'h0);
        byp_raddr1 = 5'd3;
        byp_raddr2 = 5'd0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        chk_wr("reset", 1'b0, 5'd0, 32'h0, 3'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.overflow", 64'(overflow), 64'd0);
        chk("reset.byp_hit1", 64'(byp_hit1), 64'd0);
        chk("reset.byp_data1", 64'(byp_data1), 64'd0);
        step();
        chk_wr("idle", 1'b0, 5'd0, 32'h0, 3'd0);

        // Dual enqueue into empty queue, then drain
        lane0(1'b1, 5'd3, 32'h11);
        lane1(1'b1, 5'd4, 32'h22);
        step();
        lane0(1'b0, 5'd0, 32'h0);
        lane1(1'b0, 5'd0, 32'h0);
        chk_wr("pair.c1", 1'b1, 5'd3, 32'h11, 3'd2);
        byp_raddr1 = 5'd4;
        byp_raddr2 = 5'd3;
        #1;
        chk("pair.byp_hit1", 64'(byp_hit1), 64'd1);
        chk("pair.byp_data1", 64'(byp_data1), 64'h22);
        chk("pair.head_hit2", 64'(byp_hit2), 64'd1);
        chk("pair.head_data2", 64'(byp_data2), 64'h11);
        step();
        chk_wr("pair.c2", 1'b1, 5'd4, 32'h22, 3'd1);
        chk("pair.gone_hit2", 64'(byp_hit2), 64'd0);
        chk("pair.gone_data2", 64'(byp_data2), 64'd0);
        step();
        chk_wr("pair.c3", 1'b0, 5'd0, 32'h0, 3'd0);

        // Three dual-enqueue cycles: third pair dropped
        lane0(1'b1, 5'd1, 32'h101);
        lane1(1'b1, 5'd2, 32'h102);
        step();
        chk_wr("ovf.a", 1'b1, 5'd1, 32'h101, 3'd2);
        chk("ovf.a.in_ready", 64'(in_ready), 64'd1);
        lane0(1'b1, 5'd3, 32'h103);
        lane1(1'b1, 5'd4, 32'h104);
        step();
        chk_wr("ovf.b", 1'b1, 5'd2, 32'h102, 3'd3);
        chk("ovf.b.in_ready", 64'(in_ready), 64'd0);
        chk("ovf.b.overflow", 64'(overflow), 64'd0);
        lane0(1'b1, 5'd5, 32'h105);
        lane1(1'b1, 5'd6, 32'h106);
        step();
        lane0(1'b0, 5'd0, 32'h0);
        lane1(1'b0, 5'd0, 32'h0);
        chk_wr("ovf.c", 1'b1, 5'd3, 32'h103, 3'd2);
        chk("ovf.c.overflow", 64'(overflow), 64'd1);
        step();
        chk_wr("ovf.d", 1'b1, 5'd4, 32'h104, 3'd1);
        step();
        chk_wr("ovf.e", 1'b0, 5'd0, 32'h0, 3'd0);

        // Second fill exercising pointer wrap
        lane0(1'b1, 5'd9, 32'h9);
        lane1(1'b1, 5'd10, 32'hA);
        step();
        chk_wr("wrap.a", 1'b1, 5'd9, 32'h9, 3'd2);
        lane0(1'b1, 5'd11, 32'hB);
        lane1(1'b1, 5'd12, 32'hC);
        step();
        lane0(1'b0, 5'd0, 32'h0);
        lane1(1'b0, 5'd0, 32'h0);
        chk_wr("wrap.b", 1'b1, 5'd10, 32'hA, 3'd3);
        step();
        chk_wr("wrap.c", 1'b1, 5'd11, 32'hB, 3'd2);
        lane0(1'b1, 5'd13, 32'hD);
        step();
        lane0(1'b0, 5'd0, 32'h0);
        chk_wr("wrap.d", 1'b1, 5'd12, 32'hC, 3'd2);
        step();
        chk_wr("wrap.e", 1'b1, 5'd13, 32'hD, 3'd1);
        step();
        chk_wr("wrap.f", 1'b0, 5'd0, 32'h0, 3'd0);
        chk("wrap.overflow_sticky", 64'(overflow), 64'd1);

        // Reset clears sticky overflow
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst.overflow", 64'(overflow), 64'd0);

        // Youngest-match bypass
        lane0(1'b1, 5'd5, 32'hA);
        lane1(1'b1, 5'd5, 32'hB);
        byp_raddr1 = 5'd5;
        byp_raddr2 = 5'd0;
        step();
        lane0(1'b0, 5'd0, 32'h0);
        lane1(1'b0, 5'd0, 32'h0);
        chk("byp.hit1", 64'(byp_hit1), 64'd1);
        chk("byp.data1", 64'(byp_data1), 64'hB);
        chk("byp.hit2", 64'(byp_hit2), 64'd0);
        chk("byp.data2", 64'(byp_data2), 64'd0);
        chk_wr("byp.older_first", 1'b1, 5'd5, 32'hA, 3'd2);
        step();
        chk_wr("byp.younger", 1'b1, 5'd5, 32'hB, 3'd1);
        step();
        chk("byp.empty_hit1", 64'(byp_hit1), 64'd0);

        // rd=0 discarded without overflow
        lane0(1'b1, 5'd0, 32'hFF);
        lane1(1'b1, 5'd7, 32'h77);
        step();
        lane0(1'b0, 5'd0, 32'h0);
        lane1(1'b0, 5'd0, 32'h0);
        chk_wr("rd0", 1'b1, 5'd7, 32'h77, 3'd1);
        chk("rd0.overflow", 64'(overflow), 64'd0);
        step();
        chk_wr("rd0.drained", 1'b0, 5'd0, 32'h0, 3'd0);

        // Reset mid-drain discards pending entries
        lane0(1'b1, 5'd1, 32'h201);
        lane1(1'b1, 5'd2, 32'h202);
        step();
        lane0(1'b1, 5'd3, 32'h203);
        lane1(1'b1, 5'd4, 32'h204);
        step();
        lane1(1'b0, 5'd0, 32'h0);
        chk("midrst.count3", 64'(count), 64'd3);
        lane0(1'b1, 5'd8, 32'h208);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        lane0(1'b0, 5'd0, 32'h0);
        chk_wr("midrst.r", 1'b0, 5'd0, 32'h0, 3'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_wr("midrst.after", 1'b0, 5'd0, 32'h0, 3'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_result_queue.md
Name: wb_result_queue

Overview:
- Return path of the operand datapath: buffers ALU results from two superscalar execute lanes and drains them into the single register-file write port, one entry per cycle.
- Provides youngest-match bypass lookup so operand selection sees results that have not yet been written back.
- Sits between the execute stage and the register file.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2
XLEN, 32, result data width
REG_W, 5, register index width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in0_valid  input  1  lane 0 result valid
in0_rd  input  REG_W  lane 0 destination register
in0_data  input  XLEN  lane 0 result
in1_valid  input  1  lane 1 result valid (lane 1 is program-order younger than lane 0)
in1_rd  input  REG_W  lane 1 destination register
in1_data  input  XLEN  lane 1 result
in_ready  output  1  queue can accept two results this cycle
wr_en  output  1  register-file write enable
wr_addr  output  REG_W  register-file write index
wr_data  output  XLEN  register-file write data
byp_raddr1  input  REG_W  bypass lookup index, operand 1
byp_raddr2  input  REG_W  bypass lookup index, operand 2
byp_hit1  output  1  pending result exists for byp_raddr1
byp_data1  output  XLEN  youngest pending data for byp_raddr1
byp_hit2  output  1  pending result exists for byp_raddr2
byp_data2  output  XLEN  youngest pending data for byp_raddr2
count  output  clog2(DEPTH)+1  occupied entries
overflow  output  1  sticky error flag; set when a result is dropped

Behaviour:
- Storage: circular buffer with head and tail pointers, each clog2(DEPTH) bits, wrapping mod DEPTH. Occupancy counter ranges 0..DEPTH.
- Reset (rst_n=0 at a clock edge): head=tail=0, count=0, overflow=0. All entries are invalidated.
  - Outputs after reset: wr_en=0, wr_addr=0, wr_data=0, byp_hit*=0, byp_data*=0, in_ready=1.
  - Reset takes priority over every same-cycle enqueue and dequeue. Reset in the middle of a drain discards all pending entries; they are never written.
- Enqueue:
  - A lane enqueues when its valid is 1, its rd is not 0, and in_ready is 1.
  - A result with rd=0 is discarded silently and does not count as an overflow.
  - Two results in the same cycle are written lane 0 at tail and lane 1 at tail+1, so program order is kept. Tail advances by the number enqueued (0, 1 or 2).
- in_ready = (count <= DEPTH-2).
  - Computed from registered count only; a same-cycle dequeue is not credited.
- Overflow: any valid result with rd not 0 presented while in_ready=0 is dropped. overflow is set the next cycle and stays set until reset.
- Drain:
  - wr_en = (count != 0). wr_addr and wr_data come from the head entry; they are driven 0 when the queue is empty.
  - Every cycle with wr_en=1 dequeues the head: head increments, wrapping from DEPTH-1 to 0.
  - The register file is required to accept one write per cycle unconditionally.
- Latency: a result enqueued at edge N into an empty queue appears on wr_* during cycle N+1 and is written at edge N+1. There is no same-cycle pass-through.
- Simultaneous enqueue and dequeue: count_next = count + enq_count - deq. Full and empty boundaries are exact.
- Bypass (combinational, over occupied entries only):
  - Per port, hit=1 if any occupied entry has rd equal to raddr.
  - data comes from the youngest matching entry, counting back from tail-1.
  - raddr=0 never hits; data is 0 on a miss.
  - Lanes presented in the current cycle are not searched.
  - The head entry being written this cycle still hits.
- Duplicate destinations in the queue are legal. The register file receives all writes in order, so the final value is the youngest.

Test Plan:
- Reset then idle -> wr_en=0, in_ready=1, count=0, overflow=0, byp_hit1=0.
- Empty queue; edge 0: in0 (rd=3, 0x11) and in1 (rd=4, 0x22) -> cycle 1: wr 3/0x11, count=2; cycle 2: wr 4/0x22, count=1; cycle 3: wr_en=0, count=0.
- DEPTH=4; dual enqueue for 3 consecutive cycles, 6 results rd=1..6 -> in_ready drops once count reaches 3; the third pair is dropped, overflow=1, written sequence is 1,2,3,4, and pointers wrap correctly on a second fill.
- Queue holds rd=5/0xA (older) and rd=5/0xB (younger); byp_raddr1=5, byp_raddr2=0 -> byp_hit1=1, byp_data1=0xB, byp_hit2=0.
- in0 rd=0/0xFF with in1 rd=7/0x77 -> only rd 7 is enqueued, count=1, overflow stays 0.
- Queue holds 3 entries; rst_n=0 for one edge while in0_valid=1 -> count=0, wr_en=0, nothing enqueued, no pending entry written afterward.
